mstage_hazard_unit: RTL and testbench



---
 rtl/mstage_hazard_unit.sv | 243 ++++++++++++++++++++++++
 tb/tb_mstage_hazard_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mstage_hazard_unit.sv
// Pipeline hazard controller for an N-stage in-order pipeline: occupancy tracking,
// stall/flush generation, redirect selection, drain-then-trap sequencing and bus timeout.
module mstage_hazard_unit #(
  parameter int NUM_STAGES = 3,
  parameter int EX_STAGE   = 1,
  parameter int MEM_STAGE  = NUM_STAGES - 1,
  parameter int XLEN       = 32,
  parameter int TIMEOUT_W  = 8
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       fetch_valid,
  input  logic                       i_mem_busy,
  input  logic                       dmem_access,
  input  logic                       d_mem_busy,
  input  logic                       halt,
  input  logic                       branch_redirect,
  input  logic                       ret,
  input  logic                       intr,
  input  logic [NUM_STAGES-1:0]      exc_valid,
  input  logic [NUM_STAGES*XLEN-1:0] stage_pc,
  input  logic                       priv_ack,
  output logic [NUM_STAGES-1:0]      valid,
  output logic [NUM_STAGES-1:0]      stall,
  output logic [NUM_STAGES-1:0]      flush,
  output logic                       fetch_en,
  output logic                       pc_en,
  output logic [1:0]                 npc_sel,
  output logic                       trap_req,
  output logic [XLEN-1:0]            trap_epc,
  output logic [2:0]                 trap_stage,
  output logic                       bus_timeout
);

  typedef enum logic [1:0] {RUN, DRAIN, TRAP} state_t;

  localparam logic [1:0] NPC_SEQ  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_TRAP = 2'b10;
  localparam logic [1:0] NPC_RET  = 2'b11;

  // The counter pulses on the wait cycle that would carry it to all-ones.
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'((1 << TIMEOUT_W) - 2);

  state_t state;
  state_t state_next;

  logic [NUM_STAGES-1:0] valid_q;
  logic [NUM_STAGES-1:0] valid_next;
  logic [NUM_STAGES-1:0] wait_src;
  logic [NUM_STAGES-1:0] stall_raw;
  logic [NUM_STAGES-1:0] stall_eff;
  logic [NUM_STAGES-1:0] flush_c;
  logic [NUM_STAGES-1:0] exc_hit;
  logic [NUM_STAGES-1:0] adv_in;
  logic [TIMEOUT_W-1:0]  tmo_cnt;
  logic [XLEN-1:0]       evt_pc;
  logic [2:0]            exc_k;
  logic [2:0]            old_k;
  logic [2:0]            drain_k;
  logic [2:0]            evt_k;
  logic [1:0]            npc_c;
  logic                  fetch_en_c;
  logic                  wait_any;
  logic                  exc_any;
  logic                  any_valid;
  logic                  drain_exc;
  logic                  older_latched;
  logic                  older_evt;
  logic                  evt;
  logic                  latch_en;
  logic                  pc_en_c;

  // A wait in any stage holds that stage and everything younger behind it.
  always_comb begin
    logic acc;
    fetch_en_c          = (state == RUN);
    wait_src            = '0;
    wait_src[0]         = i_mem_busy & fetch_en_c;
    wait_src[MEM_STAGE] = wait_src[MEM_STAGE] | (dmem_access & d_mem_busy);
    wait_any            = |wait_src;
    stall_raw           = '0;
    acc                 = 1'b0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      acc          = acc | wait_src[i];
      stall_raw[i] = acc | halt | (state == TRAP);
    end
    if (state == DRAIN) stall_raw[0] = 1'b1;
  end

  always_comb begin
    exc_hit       = exc_valid & valid_q;
    exc_any       = |exc_hit;
    exc_k         = '0;
    old_k         = '0;
    any_valid     = 1'b0;
    drain_exc     = 1'b0;
    drain_k       = '0;
    older_latched = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (exc_hit[i]) exc_k = 3'(i);
      if (valid_q[i]) begin
        old_k     = 3'(i);
        any_valid = 1'b1;
      end
      if (i > int'(trap_stage)) begin
        if (valid_q[i]) older_latched = 1'b1;
        if (exc_hit[i]) begin
          drain_exc = 1'b1;
          drain_k   = 3'(i);
        end
      end
    end
  end

  // Event priority in RUN: exception, interrupt, xRET, branch redirect, sequential.
  always_comb begin
    flush_c    = '0;
    pc_en_c    = 1'b0;
    npc_c      = NPC_SEQ;
    state_next = state;
    latch_en   = 1'b0;
    evt        = 1'b0;
    evt_k      = '0;
    older_evt  = 1'b0;
    case (state)
      RUN: begin
        if (!halt) begin
          if (exc_any) begin
            evt   = 1'b1;
            evt_k = exc_k;
          end else if (intr && !wait_any && any_valid) begin
            evt   = 1'b1;
            evt_k = old_k;
          end else if (ret) begin
            for (int i = 0; i < NUM_STAGES; i++)
              if (i < int'(old_k)) flush_c[i] = 1'b1;
            pc_en_c = 1'b1;
            npc_c   = NPC_RET;
          end else if (branch_redirect) begin
            for (int i = 0; i < NUM_STAGES; i++)
              if (i < EX_STAGE) flush_c[i] = 1'b1;
            pc_en_c = 1'b1;
            npc_c   = NPC_BR;
          end else begin
            pc_en_c = ~stall_raw[0];
          end
        end
        if (evt) begin
          for (int i = 0; i < NUM_STAGES; i++) begin
            if (i <= int'(evt_k)) flush_c[i] = 1'b1;
            if (i > int'(evt_k) && valid_q[i]) older_evt = 1'b1;
          end
          latch_en   = 1'b1;
          state_next = (older_evt || d_mem_busy) ? DRAIN : TRAP;
        end
      end
      DRAIN: begin
        if (!halt) begin
          if (drain_exc) begin
            evt_k    = drain_k;
            latch_en = 1'b1;
            for (int i = 0; i < NUM_STAGES; i++)
              if (i <= int'(drain_k)) flush_c[i] = 1'b1;
          end else if (!older_latched && !d_mem_busy) begin
            state_next = TRAP;
          end
        end
      end
      TRAP: begin
        if (!halt && priv_ack) begin
          flush_c    = '1;
          pc_en_c    = 1'b1;
          npc_c      = NPC_TRAP;
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    evt_pc = '0;
    for (int i = 0; i < NUM_STAGES; i++)
      if (3'(i) == evt_k) evt_pc = stage_pc[i*XLEN +: XLEN];
  end

  // A stage fed by a stalled or flushed neighbour takes a bubble.
  always_comb begin
    stall_eff  = stall_raw & ~flush_c;
    adv_in     = {valid_q[NUM_STAGES-2:0] & ~stall_eff[NUM_STAGES-2:0] & ~flush_c[NUM_STAGES-2:0],
                  fetch_valid};
    valid_next = valid_q;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (flush_c[i])         valid_next[i] = 1'b0;
      else if (!stall_raw[i]) valid_next[i] = adv_in[i];
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= RUN;
      valid_q    <= '0;
      trap_req   <= 1'b0;
      trap_epc   <= '0;
      trap_stage <= '0;
    end else begin
      state    <= state_next;
      valid_q  <= valid_next;
      trap_req <= (state_next == TRAP);
      if (latch_en) begin
        trap_epc   <= evt_pc;
        trap_stage <= evt_k;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      tmo_cnt     <= '0;
      bus_timeout <= 1'b0;
    end else if (wait_any) begin
      if (tmo_cnt == TMO_LAST) begin
        tmo_cnt     <= '0;
        bus_timeout <= 1'b1;
      end else begin
        tmo_cnt     <= tmo_cnt + 1'b1;
        bus_timeout <= 1'b0;
      end
    end else begin
      tmo_cnt     <= '0;
      bus_timeout <= 1'b0;
    end
  end

  assign valid    = valid_q;
  assign fetch_en = nRST & fetch_en_c;
  assign flush    = nRST ? flush_c : '0;
  assign stall    = nRST ? stall_eff : '0;
  assign pc_en    = nRST & pc_en_c;
  assign npc_sel  = nRST ? npc_c : NPC_SEQ;

endmodule

// File: tb/tb_mstage_hazard_unit.sv
// Directed bench for mstage_hazard_unit (3 stages, EX=1, MEM=2, 3-bit timeout):
// table of single-cycle vectors plus hand sequences for trap, drain, timeout and reset.
`timescale 1ns/1ps
module tb_mstage_hazard_unit;
  localparam int N    = 3;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            n_rst;
  logic            fetch_valid, i_mem_busy, dmem_access, d_mem_busy, halt;
  logic            branch_redirect, ret, intr, priv_ack;
  logic [N-1:0]    exc_valid;
  logic [N*XLEN-1:0] stage_pc;
  logic [N-1:0]    valid, stall, flush;
  logic            fetch_en, pc_en, trap_req, bus_timeout;
  logic [1:0]      npc_sel;
  logic [XLEN-1:0] trap_epc;
  logic [2:0]      trap_stage;

  int total_cnt = 0;
  int bad_cnt   = 0;

  typedef struct {
    logic       fv, imb, dma, dmb, hlt, br, rt;
    logic [2:0] exp_stall, exp_flush;
    logic       exp_pc_en;
    logic [1:0] exp_npc;
    logic [2:0] exp_valid;
  } vec_t;

  vec_t vecs [14];

  always #5 clk = ~clk;

  mstage_hazard_unit #(
    .NUM_STAGES(N), .EX_STAGE(1), .MEM_STAGE(2), .XLEN(XLEN), .TIMEOUT_W(3)
  ) dut (
    .CLK(clk), .nRST(n_rst), .fetch_valid(fetch_valid), .i_mem_busy(i_mem_busy),
    .dmem_access(dmem_access), .d_mem_busy(d_mem_busy), .halt(halt),
    .branch_redirect(branch_redirect), .ret(ret), .intr(intr), .exc_valid(exc_valid),
    .stage_pc(stage_pc), .priv_ack(priv_ack), .valid(valid), .stall(stall), .flush(flush),
    .fetch_en(fetch_en), .pc_en(pc_en), .npc_sel(npc_sel), .trap_req(trap_req),
    .trap_epc(trap_epc), .trap_stage(trap_stage), .bus_timeout(bus_timeout)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    fetch_valid     = v.fv;
    i_mem_busy      = v.imb;
    dmem_access     = v.dma;
    d_mem_busy      = v.dmb;
    halt            = v.hlt;
    branch_redirect = v.br;
    ret             = v.rt;
  endtask

  task automatic idle();
    fetch_valid = 0; i_mem_busy = 0; dmem_access = 0; d_mem_busy = 0; halt = 0;
    branch_redirect = 0; ret = 0; intr = 0; priv_ack = 0; exc_valid = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Three hazard-free fetches leave every stage occupied.
  task automatic fill();
    idle();
    fetch_valid = 1;
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0] fill_exp [5];
    fill_exp = '{3'b001, 3'b011, 3'b111, 3'b111, 3'b111};
    //              fv    imb   dma   dmb   hlt   br    rt    stall   flush   pc    npc    valid'
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 2'b00, 3'b111};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 2'b00, 3'b110};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 3'b000, 1'b0, 2'b00, 3'b101};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 2'b00, 3'b111};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 2'b00, 3'b111};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 2'b00, 3'b111};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 2'b00, 3'b111};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b001, 1'b1, 2'b01, 3'b100};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b001, 1'b1, 2'b01, 3'b100};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b011, 1'b1, 2'b11, 3'b000};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 3'b011, 1'b1, 2'b11, 3'b000};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b110, 3'b001, 1'b1, 2'b01, 3'b110};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b111, 3'b000, 1'b0, 2'b00, 3'b111};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b100, 3'b011, 1'b1, 2'b11, 3'b100};

    stage_pc = {32'h0000_0200, 32'h0000_0100, 32'h0000_0080};
    idle();
    n_rst = 0;
    halt = 1;
    fetch_valid = 1;
    #12;
    checkOutput("rst_valid", valid, 3'b000);
    checkOutput("rst_stall", stall, 3'b000);
    checkOutput("rst_flush", flush, 3'b000);
    checkOutput("rst_pc_en", pc_en, 1'b0);
    checkOutput("rst_npc", npc_sel, 2'b00);
    checkOutput("rst_fetch_en", fetch_en, 1'b0);
    checkOutput("rst_trap_req", trap_req, 1'b0);
    checkOutput("rst_trap_epc", trap_epc, 32'h0);
    checkOutput("rst_trap_stage", trap_stage, 3'd0);
    checkOutput("rst_bus_timeout", bus_timeout, 1'b0);
    idle();
    @(negedge clk);
    n_rst = 1;
    #1;
    checkOutput("post_rst_fetch_en", fetch_en, 1'b1);

    $display("[TB] fill stream");
    fetch_valid = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput($sformatf("fill%0d_pc_en", k), pc_en, 1'b1);
      checkOutput($sformatf("fill%0d_npc", k), npc_sel, 2'b00);
      tick();
      checkOutput($sformatf("fill%0d_valid", k), valid, fill_exp[k]);
    end

    $display("[TB] vector table");
    for (int r = 0; r < 14; r++) begin
      fill();
      applyStimulus(vecs[r]);
      #1;
      checkOutput($sformatf("row%0d_stall", r), stall, vecs[r].exp_stall);
      checkOutput($sformatf("row%0d_flush", r), flush, vecs[r].exp_flush);
      checkOutput($sformatf("row%0d_pc_en", r), pc_en, vecs[r].exp_pc_en);
      checkOutput($sformatf("row%0d_npc", r), npc_sel, vecs[r].exp_npc);
      tick();
      checkOutput($sformatf("row%0d_valid", r), valid, vecs[r].exp_valid);
      idle();
    end

    $display("[TB] data memory stall");
    fill();
    dmem_access = 1; d_mem_busy = 1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checkOutput($sformatf("dstall%0d_stall", c), stall, 3'b111);
      tick();
      checkOutput($sformatf("dstall%0d_valid", c), valid, 3'b111);
    end
    d_mem_busy = 0;
    #1;
    checkOutput("dstall_release_stall", stall, 3'b000);
    checkOutput("dstall_release_pc_en", pc_en, 1'b1);
    tick();
    idle();

    $display("[TB] exception with drain");
    fill();
    exc_valid = 3'b010;
    #1;
    checkOutput("exc_flush", flush, 3'b011);
    checkOutput("exc_pc_en", pc_en, 1'b0);
    tick();
    exc_valid = '0;
    checkOutput("exc_epc", trap_epc, 32'h100);
    checkOutput("exc_stage", trap_stage, 3'd1);
    checkOutput("exc_valid_after", valid, 3'b000);
    checkOutput("drain_trap_req", trap_req, 1'b0);
    checkOutput("drain_fetch_en", fetch_en, 1'b0);
    checkOutput("drain_stall", stall, 3'b001);
    tick();
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("trap%0d_req", c), trap_req, 1'b1);
      checkOutput($sformatf("trap%0d_stall", c), stall, 3'b111);
      checkOutput($sformatf("trap%0d_fetch_en", c), fetch_en, 1'b0);
      tick();
    end
    priv_ack = 1;
    #1;
    checkOutput("ack_npc", npc_sel, 2'b10);
    checkOutput("ack_pc_en", pc_en, 1'b1);
    checkOutput("ack_flush", flush, 3'b111);
    tick();
    priv_ack = 0;
    checkOutput("ack_trap_req_drop", trap_req, 1'b0);
    checkOutput("ack_fetch_en", fetch_en, 1'b1);

    $display("[TB] interrupt, halt in trap, stray ack");
    fill();
    priv_ack = 1;
    #1;
    checkOutput("stray_ack_npc", npc_sel, 2'b00);
    checkOutput("stray_ack_flush", flush, 3'b000);
    tick();
    priv_ack = 0;
    checkOutput("stray_ack_trap_req", trap_req, 1'b0);
    intr = 1; i_mem_busy = 1;
    #1;
    checkOutput("intr_wait_flush", flush, 3'b000);
    tick();
    checkOutput("intr_wait_trap_req", trap_req, 1'b0);
    fill();
    intr = 1;
    #1;
    checkOutput("intr_flush", flush, 3'b111);
    checkOutput("intr_pc_en", pc_en, 1'b0);
    tick();
    intr = 0;
    checkOutput("intr_trap_req", trap_req, 1'b1);
    checkOutput("intr_stage", trap_stage, 3'd2);
    checkOutput("intr_epc", trap_epc, 32'h200);
    halt = 1; priv_ack = 1;
    #1;
    checkOutput("halt_ack_flush", flush, 3'b000);
    checkOutput("halt_ack_pc_en", pc_en, 1'b0);
    tick();
    checkOutput("halt_trap_req", trap_req, 1'b1);
    halt = 0;
    #1;
    checkOutput("late_ack_npc", npc_sel, 2'b10);
    tick();
    priv_ack = 0;
    checkOutput("late_ack_trap_req", trap_req, 1'b0);

    $display("[TB] bus timeout");
    idle();
    repeat (2) tick();
    i_mem_busy = 1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      checkOutput($sformatf("tmo_cycle%0d", n), bus_timeout, (n == 7) ? 1'b1 : 1'b0);
    end
    i_mem_busy = 0;
    tick();
    checkOutput("tmo_after", bus_timeout, 1'b0);

    $display("[TB] drain with memory busy and re-latch");
    fill();
    exc_valid = 3'b010; dmem_access = 1; d_mem_busy = 1;
    #1;
    checkOutput("dr_a_flush", flush, 3'b011);
    checkOutput("dr_a_stall", stall, 3'b100);
    tick();
    checkOutput("dr_a_stage", trap_stage, 3'd1);
    checkOutput("dr_a_valid", valid, 3'b100);
    exc_valid = '0;
    #1;
    checkOutput("dr_b_trap_req", trap_req, 1'b0);
    checkOutput("dr_b_fetch_en", fetch_en, 1'b0);
    tick();
    checkOutput("dr_b_valid", valid, 3'b100);
    exc_valid = 3'b100;
    #1;
    checkOutput("dr_c_flush", flush, 3'b111);
    tick();
    checkOutput("dr_c_stage", trap_stage, 3'd2);
    checkOutput("dr_c_epc", trap_epc, 32'h200);
    checkOutput("dr_c_valid", valid, 3'b000);
    checkOutput("dr_c_trap_req", trap_req, 1'b0);
    exc_valid = '0; d_mem_busy = 0; dmem_access = 0;
    tick();
    checkOutput("dr_d_trap_req", trap_req, 1'b1);

    $display("[TB] reset in trap");
    #2;
    n_rst = 0;
    #1;
    checkOutput("midrst_trap_req", trap_req, 1'b0);
    checkOutput("midrst_valid", valid, 3'b000);
    checkOutput("midrst_stall", stall, 3'b000);
    checkOutput("midrst_fetch_en", fetch_en, 1'b0);
    checkOutput("midrst_stage", trap_stage, 3'd0);
    @(negedge clk);
    n_rst = 1;
    tick();
    checkOutput("midrst_run_fetch_en", fetch_en, 1'b1);
    checkOutput("midrst_run_trap_req", trap_req, 1'b0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
